// File: rtl/alu_operand_sequencer.sv
// Operand/accumulator stage in front of the 8-bit ALU.
// Holds A, B and sub for the ALU inputs and sequences LDA/ADD/SUB/OUT requests.
// It writes the ALU result back into A and captures the Z and C flags.
module alu_operand_sequencer #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] op_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_sub,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic [DATA_W-1:0] a_q,
  output logic              flag_z,
  output logic              flag_c,
  output logic [DATA_W-1:0] out_q,
  output logic              done
);

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  // Settle counter reload value; SETTLE_CYCLES is limited to 1..15, so 4 bits are enough.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WB     = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_sub;
  logic [DATA_W-1:0] r_out;
  logic              r_flag_z;
  logic              r_flag_c;
  logic              r_done;
  logic              w_accept;
  logic              w_arith;

  assign op_ready = (r_state == ST_IDLE);
  assign w_accept = op_valid & op_ready;
  // ADD and SUB are the only requests that go through the ALU.
  assign w_arith  = (op_code == OP_ADD) || (op_code == OP_SUB);

  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_sub = r_sub;
  assign a_q     = r_a;
  assign flag_z  = r_flag_z;
  assign flag_c  = r_flag_c;
  assign out_q   = r_out;
  assign done    = r_done;

  // State register and settle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic. LDA and OUT complete in IDLE; ADD and SUB wait in SETTLE before writeback.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_arith) begin
          w_state_next = ST_SETTLE;
          w_cnt_next   = CNT_INIT;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ST_WB;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_WB: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // Datapath: operand capture on accept, result and flag writeback in WB, and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_out    <= '0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        case (op_code)
          OP_LDA: begin
            r_a    <= op_data;
            r_done <= 1'b1;
          end
          OP_OUT: begin
            r_out  <= r_a;
            r_done <= 1'b1;
          end
          default: begin
            // b and sub stay on the ALU after WB until the next ADD/SUB.
            r_b   <= op_data;
            r_sub <= (op_code == OP_SUB);
          end
        endcase
      end
      if (r_state == ST_WB) begin
        r_a      <= alu_result;
        r_flag_c <= alu_carry;
        r_flag_z <= (alu_result == '0);
        r_done   <= 1'b1;
      end
    end
  end

endmodule
